// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared FSM states and hex segment constants for the display scanner
package seg7_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_e;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to high-true {g,f,e,d,c,b,a} decode
module hex_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TAB[nib_i];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display scanner stepped by a synchronized divider output
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic                  frame_done
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [7:0] BLAST = 8'(BLANK_CYCLES - 1);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
  logic s1_q, s2_q, s3_q, step;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0] dpm_q, dpm_d;
  logic blz_q, blz_d;
  logic [DIGITS-1:0] an_d, lz;
  logic [6:0] seg_d, dec;
  logic [3:0] nib;
  logic sdp_d, fd_d, zr, show;
  assign step = s2_q & ~s3_q;
  // two-flop synchronizer for div_in plus a delay stage for rising-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1_q, s2_q, s3_q} <= 3'b000;
    else {s1_q, s2_q, s3_q} <= {div_in, s1_q, s2_q};
  // next state: steps only advance from IDLE/SHOW; BLANK just counts down its gap
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    val_d = val_q;
    dpm_d = dpm_q;
    blz_d = blz_q;
    fd_d = 1'b0;
    if (state_q == BLANK) begin
      cnt_d = cnt_q + 8'd1;
      state_d = (cnt_q == BLAST) ? SHOW : BLANK;
    end else if (step) begin
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      cnt_d = 8'd0;
      idx_d = (state_q == IDLE || idx_q == LAST) ? '0 : idx_q + 1'b1;
      fd_d = (state_q == SHOW) && (idx_q == LAST);
      val_d = (idx_d == '0) ? value : val_q;
      dpm_d = (idx_d == '0) ? dp : dpm_q;
      blz_d = (idx_d == '0) ? blank_lz : blz_q;
    end
  end
  // leading-zero mask: digits above the first nonzero nibble, digit 0 excluded
  always_comb begin
    zr = blz_d;
    lz = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zr = zr & (val_d[4*i +: 4] == 4'h0);
      lz[i] = zr;
    end
  end
  assign nib = val_d[4*idx_d +: 4];
  hex_to_seg7 u_dec (.nib_i(nib), .seg_o(dec));
  // pin-level outputs derived from next state so they move with the state register
  always_comb begin
    show = (state_d == SHOW);
    an_d = (show ? DIGITS'(1) << idx_d : '0) ^ AN_OFF;
    seg_d = ((show && !lz[idx_d]) ? dec : SEG_OFF) ^ SEG_INV;
    sdp_d = (show & dpm_d[idx_d]) ^ ACTIVE_LOW;
  end
  // state, index, blank counter and frame snapshot registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= 8'd0;
      val_q <= '0;
      dpm_q <= '0;
      blz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      dpm_q <= dpm_d;
      blz_q <= blz_d;
    end
  // output registers, reset to the inactive pin level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      an <= AN_OFF;
      seg <= SEG_OFF ^ SEG_INV;
      seg_dp <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      an <= an_d;
      seg <= seg_d;
      seg_dp <= sdp_d;
      frame_done <= fd_d;
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed vector bench for the display scanner
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic div_a = 1'b0, div_b = 1'b0, div_c = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0;
  logic blz = 1'b0;
  logic [3:0] an_a, an_b;
  logic [2:0] an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic sdp_a, sdp_b, sdp_c, fd_a_o, fd_b_o, fd_c_o;
  int checks = 0, errors = 0;
  int fd_a = 0, fd_c = 0, c_bad = 0;
  bit c_on = 1'b0;

  seg7_scan #(.DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .div_in(div_a), .value(value), .dp(dp), .blank_lz(blz),
    .an(an_a), .seg(seg_a), .seg_dp(sdp_a), .frame_done(fd_a_o));
  seg7_scan #(.DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .div_in(div_b), .value(value), .dp(dp), .blank_lz(blz),
    .an(an_b), .seg(seg_b), .seg_dp(sdp_b), .frame_done(fd_b_o));
  seg7_scan #(.DIGITS(3), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .div_in(div_c), .value(value[11:0]), .dp(dp[2:0]), .blank_lz(blz),
    .an(an_c), .seg(seg_c), .seg_dp(sdp_c), .frame_done(fd_c_o));

  always @(negedge clk) begin
    if (fd_a_o) fd_a++;
    if (fd_c_o) fd_c++;
    if (c_on && !(an_c inside {3'b110, 3'b101, 3'b011})) c_bad++;
  end

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        sdp;
    int          fd;
    int          gap;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_a(output int gap, output bit to);
    int t = 0;
    @(negedge clk) div_a = 1'b1;
    while (an_a != 4'hF && t < 20) begin @(negedge clk); t++; end
    gap = 0;
    while (an_a == 4'hF && t < 60) begin @(negedge clk); gap++; t++; end
    to = (t >= 60);
    div_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_b(input int hi, input int lo);
    @(negedge clk) div_b = 1'b1;
    repeat (hi) @(negedge clk);
    div_b = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_c();
    @(negedge clk) div_c = 1'b1;
    repeat (3) @(negedge clk);
    div_c = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int gap, f0;
    bit to;
    tbl[0]  = '{16'h12AF, 4'h0, 1'b0, 4'hE, 7'h0E, 1'b1, 0, -1};
    tbl[1]  = '{16'h12AF, 4'h0, 1'b0, 4'hD, 7'h08, 1'b1, 0, 2};
    tbl[2]  = '{16'h12AF, 4'h0, 1'b0, 4'hB, 7'h24, 1'b1, 0, 2};
    tbl[3]  = '{16'h0000, 4'h0, 1'b0, 4'h7, 7'h79, 1'b1, 0, 2};
    tbl[4]  = '{16'h0000, 4'h5, 1'b0, 4'hE, 7'h40, 1'b0, 1, 2};
    tbl[5]  = '{16'h0050, 4'h0, 1'b1, 4'hD, 7'h40, 1'b1, 0, 2};
    tbl[6]  = '{16'h0050, 4'h0, 1'b1, 4'hB, 7'h40, 1'b0, 0, 2};
    tbl[7]  = '{16'h0050, 4'h0, 1'b1, 4'h7, 7'h40, 1'b1, 0, 2};
    tbl[8]  = '{16'h0050, 4'h8, 1'b1, 4'hE, 7'h40, 1'b1, 1, 2};
    tbl[9]  = '{16'h0050, 4'h8, 1'b1, 4'hD, 7'h12, 1'b1, 0, 2};
    tbl[10] = '{16'h0050, 4'h8, 1'b1, 4'hB, 7'h7F, 1'b1, 0, 2};
    tbl[11] = '{16'h0050, 4'h8, 1'b1, 4'h7, 7'h7F, 1'b0, 0, 2};
    tbl[12] = '{16'h0000, 4'h0, 1'b1, 4'hE, 7'h40, 1'b1, 1, 2};
    tbl[13] = '{16'h0000, 4'h0, 1'b1, 4'hD, 7'h7F, 1'b1, 0, 2};
    tbl[14] = '{16'h0000, 4'h0, 1'b1, 4'hB, 7'h7F, 1'b1, 0, 2};
    tbl[15] = '{16'h0000, 4'h0, 1'b1, 4'h7, 7'h7F, 1'b1, 0, 2};
    tbl[16] = '{16'h8001, 4'h0, 1'b1, 4'hE, 7'h79, 1'b1, 1, 2};
    tbl[17] = '{16'h8001, 4'h0, 1'b1, 4'hD, 7'h40, 1'b1, 0, 2};
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_dp", 32'(sdp_a), 32'h1);
    chk("rst_fd", 32'(fd_a_o), 32'h0);
    chk("rst_an_c", 32'(an_c), 32'h7);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      value = tbl[i].value;
      dp = tbl[i].dp;
      blz = tbl[i].blz;
      f0 = fd_a;
      pulse_a(gap, to);
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'h0);
      chk($sformatf("v%0d_an", i), 32'(an_a), 32'(tbl[i].an));
      chk($sformatf("v%0d_seg", i), 32'(seg_a), 32'(tbl[i].seg));
      chk($sformatf("v%0d_dp", i), 32'(sdp_a), 32'(tbl[i].sdp));
      chk($sformatf("v%0d_fd", i), 32'(fd_a - f0), 32'(tbl[i].fd));
      if (tbl[i].gap >= 0) chk($sformatf("v%0d_gap", i), 32'(gap), 32'(tbl[i].gap));
    end
    pulse_b(3, 3);
    repeat (30) @(negedge clk);
    chk("b_digit0", 32'(an_b), 32'hE);
    pulse_b(3, 7);
    pulse_b(3, 0);
    chk("b_blank_mid", 32'(an_b), 32'hF);
    repeat (30) @(negedge clk);
    chk("b_drop_step", 32'(an_b), 32'hD);
    @(negedge clk) div_b = 1'b1;
    repeat (40) @(negedge clk);
    chk("b_hold_once", 32'(an_b), 32'hB);
    repeat (60) @(negedge clk);
    chk("b_hold_stay", 32'(an_b), 32'hB);
    div_b = 1'b0;
    pulse_c();
    chk("c_d0", 32'(an_c), 32'h6);
    c_on = 1'b1;
    pulse_c();
    chk("c_d1", 32'(an_c), 32'h5);
    pulse_c();
    chk("c_d2", 32'(an_c), 32'h3);
    pulse_c();
    chk("c_wrap", 32'(an_c), 32'h6);
    chk("c_fd", 32'(fd_c), 32'h1);
    chk("c_nogap", 32'(c_bad), 32'h0);
    c_on = 1'b0;
    @(negedge clk);
    chk("pre_rst_an", 32'(an_a), 32'hD);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an_a), 32'hF);
    chk("mid_rst_seg", 32'(seg_a), 32'h7F);
    chk("mid_rst_dp", 32'(sdp_a), 32'h1);
    chk("mid_rst_fd", 32'(fd_a_o), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
